wb_slave_mux: RTL and testbench

//  Wishbone classic front-end between the Caravel user-area slave port and the user

---
 rtl/wb_mux_pkg.sv | 18 +
 rtl/wb_mux_timeout.sv | 22 ++
 rtl/wb_slave_mux.sv | 119 +++++++++++
 tb/tb_wb_slave_mux.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_mux_pkg.sv
// wb_mux_pkg: shared types, default address map and decode helper for the Wishbone slave mux
// Holds the FSM state enum, the slave-select enum and the default base/mask/data constants
// that the mux top and the dino register bank agree on.
package wb_mux_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
    typedef enum logic [1:0] {S0, S1, NONE} slv_t;
    localparam logic [31:0] DEF_S0_BASE      = 32'h3000_0000;
    localparam logic [31:0] DEF_S1_BASE      = 32'h3100_0000;
    localparam logic [31:0] DEF_ADDR_MASK    = 32'hFF00_0000;
    localparam logic [31:0] DEF_UNMAP_DATA   = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hBAD0_0000;
    localparam int          DEF_TIMEOUT_CYC  = 256;
    // Slave 0 wins when both windows match.
    function automatic slv_t decode(input logic [31:0] adr, input logic [31:0] s0_base,
                                    input logic [31:0] s1_base, input logic [31:0] mask);
        return ((adr & mask) == s0_base) ? S0 : ((adr & mask) == s1_base) ? S1 : NONE;
    endfunction
endpackage

// File: rtl/wb_mux_timeout.sv
// wb_mux_timeout: counts ACTIVE cycles and strobes expire on the last allowed one
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   active    high while the mux FSM is in ACTIVE
//   expire    high in the TIMEOUT_CYC-th consecutive ACTIVE cycle
module wb_mux_timeout #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYC) + 1;
    logic [W-1:0] cnt;
    // Held at zero outside ACTIVE, so each entry into ACTIVE starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || !active) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
    assign expire = active && (cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: Wishbone classic decoder from the Caravel slave port to the AES core and dino regs
// Optional feature macro: WB_TIMEOUT_EN (forced termination of hung slave cycles).
// Ports:
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   wbs_cyc/stb/we/sel/adr/dat_i    master request
//   wbs_ack_o, wbs_dat_o            registered one-cycle ack and read data
//   sN_cyc/stb/we/sel/adr/dat_o     slave N request (N=0 AES, N=1 dino regs)
//   sN_ack_i, sN_dat_i              slave N response
//   timeout_flag_o, timeout_cnt_o   sticky timeout flag and saturating timeout count
module wb_slave_mux
    import wb_mux_pkg::*;
#(
    parameter logic [31:0] S0_BASE      = DEF_S0_BASE,
    parameter logic [31:0] S1_BASE      = DEF_S1_BASE,
    parameter logic [31:0] ADDR_MASK    = DEF_ADDR_MASK,
    parameter logic [31:0] UNMAP_DATA   = DEF_UNMAP_DATA,
    parameter int          TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter logic [31:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        s0_cyc_o,
    output logic        s0_stb_o,
    output logic        s0_we_o,
    output logic [3:0]  s0_sel_o,
    output logic [27:0] s0_adr_o,
    output logic [31:0] s0_dat_o,
    input  logic        s0_ack_i,
    input  logic [31:0] s0_dat_i,
    output logic        s1_cyc_o,
    output logic        s1_stb_o,
    output logic        s1_we_o,
    output logic [3:0]  s1_sel_o,
    output logic [27:0] s1_adr_o,
    output logic [31:0] s1_dat_o,
    input  logic        s1_ack_i,
    input  logic [31:0] s1_dat_i,
    output logic        timeout_flag_o,
    output logic [7:0]  timeout_cnt_o
);
    state_t      state, state_n;
    slv_t        sel_q;
    logic        active, take_ack, fin, expire;
    logic [31:0] rdat, resp_dat;

    assign active   = state == ACTIVE;
    assign s0_cyc_o = active && sel_q == S0 && wbs_cyc_i;
    assign s0_stb_o = active && sel_q == S0 && wbs_stb_i;
    assign s1_cyc_o = active && sel_q == S1 && wbs_cyc_i;
    assign s1_stb_o = active && sel_q == S1 && wbs_stb_i;
    assign s0_we_o  = wbs_we_i;
    assign s1_we_o  = wbs_we_i;
    assign s0_sel_o = wbs_sel_i;
    assign s1_sel_o = wbs_sel_i;
    assign s0_adr_o = wbs_adr_i[27:0];
    assign s1_adr_o = wbs_adr_i[27:0];
    assign s0_dat_o = wbs_dat_i;
    assign s1_dat_o = wbs_dat_i;

    // An unmapped cycle behaves like a slave that acks at once with UNMAP_DATA.
    assign take_ack = sel_q == S0 ? s0_ack_i : sel_q == S1 ? s1_ack_i : 1'b1;
    assign rdat     = sel_q == S0 ? s0_dat_i : sel_q == S1 ? s1_dat_i : UNMAP_DATA;
    assign resp_dat = take_ack ? rdat : TIMEOUT_DATA;
    // Dropping cyc aborts the cycle even if an ack arrives alongside it.
    assign fin      = active && wbs_cyc_i && (take_ack || expire);

    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = (wbs_cyc_i && wbs_stb_i) ? ACTIVE : IDLE;
        else if (state == ACTIVE) state_n = !wbs_cyc_i ? IDLE : fin ? RESP : ACTIVE;
        else state_n = IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            sel_q     <= NONE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            state     <= state_n;
            if (state == IDLE && wbs_cyc_i && wbs_stb_i)
                sel_q <= decode(wbs_adr_i, S0_BASE, S1_BASE, ADDR_MASK);
            wbs_ack_o <= fin;
            if (fin) wbs_dat_o <= resp_dat;
        end
    end

`ifdef WB_TIMEOUT_EN
    logic tmo;
    wb_mux_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk(wb_clk_i), .rst(wb_rst_i), .active(active), .expire(expire)
    );
    // A same-cycle ack outranks expiry, so only ack-less terminations count.
    assign tmo = fin && !take_ack;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            timeout_flag_o <= 1'b0;
            timeout_cnt_o  <= '0;
        end else if (tmo) begin
            timeout_flag_o <= 1'b1;
            timeout_cnt_o  <= timeout_cnt_o + {7'd0, timeout_cnt_o != 8'hFF};
        end
    end
`else
    // TIMEOUT_CYC < 2 is never a legal setting, so expiry is constant low here.
    assign expire         = TIMEOUT_CYC < 2;
    assign timeout_flag_o = 1'b0;
    assign timeout_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_wb_slave_mux.sv
module tb_wb_slave_mux;
    localparam int TC = 8;
    logic        clk = 0, rst = 1;
    logic        cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, wdat = 0;
    logic        ack;
    logic [31:0] dat_o;
    logic        s0_cyc_o, s0_stb_o, s0_we_o, s1_cyc_o, s1_stb_o, s1_we_o;
    logic [3:0]  s0_sel_o, s1_sel_o;
    logic [27:0] s0_adr_o, s1_adr_o;
    logic [31:0] s0_dat_o, s1_dat_o;
    logic        s0_ack = 0, s1_ack = 0;
    logic [31:0] s0_dat = 0, s1_dat = 0;
    logic        tflag;
    logic [7:0]  tcnt;
    int checks = 0, failures = 0;
    int exp_tcnt = 0;
    logic [31:0] last_dat = 0;

    always #5 clk = ~clk;

    wb_slave_mux #(.TIMEOUT_CYC(TC)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s0_we_o(s0_we_o), .s0_sel_o(s0_sel_o),
        .s0_adr_o(s0_adr_o), .s0_dat_o(s0_dat_o), .s0_ack_i(s0_ack), .s0_dat_i(s0_dat),
        .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o), .s1_we_o(s1_we_o), .s1_sel_o(s1_sel_o),
        .s1_adr_o(s1_adr_o), .s1_dat_o(s1_dat_o), .s1_ack_i(s1_ack), .s1_dat_i(s1_dat),
        .timeout_flag_o(tflag), .timeout_cnt_o(tcnt)
    );

    // Address map: 0x30xx_xxxx -> AES, 0x31xx_xxxx -> dino regs, anything else unmapped (2).
    function automatic int target(input logic [31:0] a);
        return a[31:24] == 8'h30 ? 0 : a[31:24] == 8'h31 ? 1 : 2;
    endfunction

    // One master transaction; the addressed slave acks after d cycles of seeing stb.
    task automatic txn(input string nm, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] sl, input int d, input logic [31:0] rd);
        int t, lat, act, exp_lat;
        bit stray, pass_bad, tmo;
        logic [31:0] exp_dat, got_dat;
        t = target(a); lat = 0; act = 0; stray = 0; pass_bad = 0; tmo = 0; got_dat = 0;
`ifdef WB_TIMEOUT_EN
        tmo = (t != 2) && (d > TC - 1);
`endif
        exp_lat = t == 2 ? 2 : tmo ? TC + 1 : d + 2;
        exp_dat = t == 2 ? 32'hDEAD_BEEF : tmo ? 32'hBAD0_0000 : rd;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL %s idle_ack got=%b exp=0", nm, ack); end
        cyc = 1; stb = 1; we = w; adr = a; wdat = wd; sel = sl;
        for (int n = 1; n <= TC + 40 && lat == 0; n++) begin
            @(negedge clk);
            s0_ack = 0; s1_ack = 0; s0_dat = $urandom; s1_dat = $urandom;
            if ((t != 0 && (s0_cyc_o || s0_stb_o)) || (t != 1 && (s1_cyc_o || s1_stb_o))) stray = 1;
            if (ack) begin
                lat = n; got_dat = dat_o;
            end else if ((t == 0 && s0_stb_o) || (t == 1 && s1_stb_o)) begin
                if (t == 0 ? (s0_adr_o !== a[27:0] || s0_we_o !== w || s0_dat_o !== wd || s0_sel_o !== sl || !s0_cyc_o)
                           : (s1_adr_o !== a[27:0] || s1_we_o !== w || s1_dat_o !== wd || s1_sel_o !== sl || !s1_cyc_o))
                    pass_bad = 1;
                if (act == d) begin
                    if (t == 0) begin s0_ack = 1; s0_dat = rd; end
                    else begin s1_ack = 1; s1_dat = rd; end
                end
                act++;
            end
        end
        cyc = 0; stb = 0;
        if (tmo && exp_tcnt < 255) exp_tcnt++;
        checks += 6;
        if (lat !== exp_lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat); end
        if (got_dat !== exp_dat) begin failures++; $display("FAIL %s dat_o got=%h exp=%h", nm, got_dat, exp_dat); end
        if (stray) begin failures++; $display("FAIL %s stray_slave_strobe got=1 exp=0", nm); end
        if (pass_bad) begin failures++; $display("FAIL %s passthrough got=bad exp=match", nm); end
        if (tflag !== (exp_tcnt > 0)) begin failures++; $display("FAIL %s tflag got=%b exp=%b", nm, tflag, exp_tcnt > 0); end
        if (tcnt !== 8'(exp_tcnt)) begin failures++; $display("FAIL %s tcnt got=%0d exp=%0d", nm, tcnt, exp_tcnt); end
        last_dat = exp_dat;
    endtask

    task automatic test_reset();
        rst = 1; cyc = 1; stb = 1; adr = 32'h3000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        checks += 5;
        if (ack !== 1'b0 || dat_o !== 32'd0) begin failures++; $display("FAIL reset ack/dat got=%b/%h exp=0/0", ack, dat_o); end
        if (s0_cyc_o !== 1'b0 || s0_stb_o !== 1'b0) begin failures++; $display("FAIL reset s0_cyc got=%b exp=0", s0_cyc_o); end
        if (s1_cyc_o !== 1'b0 || s1_stb_o !== 1'b0) begin failures++; $display("FAIL reset s1_cyc got=%b exp=0", s1_cyc_o); end
        if (tflag !== 1'b0) begin failures++; $display("FAIL reset tflag got=%b exp=0", tflag); end
        if (tcnt !== 8'd0) begin failures++; $display("FAIL reset tcnt got=%0d exp=0", tcnt); end
        cyc = 0; stb = 0;
    endtask

    task automatic test_directed();
        txn("s0_read", 32'h3000_0010, 0, 32'h0, 4'hF, 0, 32'h1234_5678);
        txn("s1_write", 32'h3100_0004, 1, 32'h0000_00A5, 4'h1, 3, 32'h0BAD_CAFE);
        txn("unmapped", 32'h3200_0000, 0, 32'h0, 4'hF, 0, 32'h0);
        txn("unmapped_wr", 32'h0000_1000, 1, 32'h5555_AAAA, 4'hF, 0, 32'h0);
    endtask

    task automatic test_back_to_back();
        txn("b2b_a", 32'h3100_0100, 0, 32'h0, 4'hF, 0, 32'hA0A0_0001);
        txn("b2b_b", 32'h3000_0200, 1, 32'hCAFE_F00D, 4'h3, 1, 32'hA0A0_0002);
        txn("b2b_c", 32'h30FF_FFFC, 0, 32'h0, 4'hF, 2, 32'hA0A0_0003);
    endtask

    task automatic test_abort();
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3100_0020;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s1_cyc_o !== 1'b1) begin failures++; $display("FAIL abort s1_cyc_pending got=%b exp=1", s1_cyc_o); end
        cyc = 0; stb = 0;
        #1;
        checks++;
        if (s1_cyc_o !== 1'b0 || s1_stb_o !== 1'b0) begin failures++; $display("FAIL abort s1_cyc_drop got=%b exp=0", s1_cyc_o); end
        @(negedge clk);
        s1_ack = 1; s1_dat = 32'h7777_7777;
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL abort ack_t3 got=%b exp=0", ack); end
        @(negedge clk);
        s1_ack = 0;
        checks += 2;
        if (ack !== 1'b0) begin failures++; $display("FAIL abort late_ack got=%b exp=0", ack); end
        if (dat_o !== last_dat) begin failures++; $display("FAIL abort dat_hold got=%h exp=%h", dat_o, last_dat); end
        txn("after_abort", 32'h3100_0024, 0, 32'h0, 4'hF, 1, 32'h2468_ACE0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0040;
        @(negedge clk);
        checks++;
        if (s0_cyc_o !== 1'b1) begin failures++; $display("FAIL rstmid s0_cyc_active got=%b exp=1", s0_cyc_o); end
        rst = 1; cyc = 0; stb = 0;
        @(negedge clk);
        rst = 0; exp_tcnt = 0;
        checks += 3;
        if (ack !== 1'b0 || dat_o !== 32'd0) begin failures++; $display("FAIL rstmid ack/dat got=%b/%h exp=0/0", ack, dat_o); end
        if (s0_cyc_o !== 1'b0) begin failures++; $display("FAIL rstmid s0_cyc got=%b exp=0", s0_cyc_o); end
        if (tflag !== 1'b0 || tcnt !== 8'd0) begin failures++; $display("FAIL rstmid tstat got=%b/%0d exp=0/0", tflag, tcnt); end
        txn("after_rst", 32'h3000_0044, 0, 32'h0, 4'hF, 0, 32'h1357_9BDF);
    endtask

    task automatic test_timeout();
`ifdef WB_TIMEOUT_EN
        txn("tmo_s0", 32'h3000_0000, 0, 32'h0, 4'hF, 1000, 32'h0);
        txn("tmo_recover", 32'h3000_0010, 0, 32'h0, 4'hF, 0, 32'h1234_5678);
        txn("tmo_ack_wins", 32'h3100_0008, 0, 32'h0, 4'hF, TC - 1, 32'h0F0F_0F0F);
        txn("tmo_s1", 32'h3100_0000, 1, 32'h1, 4'hF, 1000, 32'h0);
        while (exp_tcnt < 255) txn("tmo_fill", 32'h3000_0000, 0, 32'h0, 4'hF, 1000, 32'h0);
        txn("tmo_sat", 32'h3100_0000, 0, 32'h0, 4'hF, 1000, 32'h0);
`else
        txn("slow_s0", 32'h3000_0000, 0, 32'h0, 4'hF, TC + 20, 32'h8765_4321);
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            int k;
            k = $urandom_range(0, 3);
            a = $urandom;
            a[31:24] = k == 0 ? 8'h30 : k == 1 ? 8'h31 : k == 2 ? 8'h32 : a[31:24];
            txn("random", a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
